demux_lane_sched: RTL and testbench

Lane scheduler and controller for the 1-to-2 byte demux datapath, running in the clk_2f domain.
- Steers each valid input byte to lane 0 or lane 1 in strict alternation.
- Stalls upstream when the target lane signals pause.
- Realigns the lane pointer on a frame sync.
- Counts words issued per lane and flags upstream protocol violations.
- Sits between the serial-to-parallel front end and the two per-lane FIFOs.

---
 rtl/demux_pkg.sv | 16 +
 rtl/lane_out_reg.sv | 46 ++++
 rtl/demux_lane_sched.sv | 91 +++++++++
 tb/tb_demux_lane_sched.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-2 byte demux lane scheduler.
// No logic; latency and backpressure are defined by the modules that import it.
package demux_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/lane_out_reg.sv
// One lane's output register, valid flag and wrapping issued-word counter.
// Latency 1 cycle from issue; no backpressure (data holds while issue is low).
module lane_out_reg #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              issue_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  words_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  words_q, words_d;

    always_comb begin
        data_d  = data_q;
        valid_d = issue_i;
        words_d = words_q;
        if (issue_i) begin
            data_d  = data_i;
            words_d = words_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            words_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            words_q <= words_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign words_o = words_q;

endmodule

// File: rtl/demux_lane_sched.sv
// Steers valid bytes to lane 0/1 in strict alternation, realigned to lane 0 by sync_in.
// Latency 1 cycle; backpressure: ready_in drops while the target lane pauses (no lane skipping).
module demux_lane_sched
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              sync_in,
    input  logic              pause_0,
    input  logic              pause_1,
    output logic              ready_in,
    output logic [DATA_W-1:0] data_out_0,
    output logic              valid_out_0,
    output logic [DATA_W-1:0] data_out_1,
    output logic              valid_out_1,
    output logic              selector,
    output logic [CNT_W-1:0]  words_0,
    output logic [CNT_W-1:0]  words_1,
    output logic              err_ovf
);

    state_t state_q, state_d;
    logic   sel_q, sel_d;
    logic   err_q, err_d;
    logic   tgt, pause_tgt, accept, issue_0, issue_1;

    always_comb begin
        tgt       = sync_in ? LANE0 : sel_q;
        pause_tgt = (tgt == LANE1) ? pause_1 : pause_0;
        // In IDLE with reset low the scheduler is already willing to accept.
        ready_in  = !reset && !pause_tgt;
        accept    = valid_in && ready_in;
        issue_0   = accept && (tgt == LANE0);
        issue_1   = accept && (tgt == LANE1);
    end

    always_comb begin
        state_d = ST_RUN;
        sel_d   = sel_q;
        err_d   = err_q;
        if (accept) begin
            sel_d = ~tgt;
        end else if (sync_in) begin
            sel_d = LANE0;
        end
        if (valid_in && !ready_in && (state_q == ST_RUN)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    lane_out_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane0 (
        .clk_2f  (clk_2f),
        .reset   (reset),
        .issue_i (issue_0),
        .data_i  (data_in),
        .data_o  (data_out_0),
        .valid_o (valid_out_0),
        .words_o (words_0)
    );

    lane_out_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane1 (
        .clk_2f  (clk_2f),
        .reset   (reset),
        .issue_i (issue_1),
        .data_i  (data_in),
        .data_o  (data_out_1),
        .valid_o (valid_out_1),
        .words_o (words_1)
    );

    assign selector = sel_q;
    assign err_ovf  = err_q;

endmodule

// File: tb/tb_demux_lane_sched.sv
// Bench for demux_lane_sched: directed scenarios then random traffic against a lane-level model.
module tb_demux_lane_sched;

    logic       clk_2f = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in, sync_in, pause_0, pause_1;
    logic       ready_in;
    logic [7:0] data_out_0, data_out_1;
    logic       valid_out_0, valid_out_1, selector, err_ovf;
    logic [7:0] words_0, words_1;

    demux_lane_sched dut (
        .clk_2f      (clk_2f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .sync_in     (sync_in),
        .pause_0     (pause_0),
        .pause_1     (pause_1),
        .ready_in    (ready_in),
        .data_out_0  (data_out_0),
        .valid_out_0 (valid_out_0),
        .data_out_1  (data_out_1),
        .valid_out_1 (valid_out_1),
        .selector    (selector),
        .words_0     (words_0),
        .words_1     (words_1),
        .err_ovf     (err_ovf)
    );

    always #5 clk_2f = ~clk_2f;

    int checks = 0;
    int errors = 0;

    // Model: "next lane" pointer plus per-lane last word, valid and issue count.
    int  m_next;
    int  m_data [2];
    bit  m_vld  [2];
    int  m_cnt  [2];
    bit  m_err;
    bit  m_running;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_next = 0;
        m_err = 0;
        m_running = 0;
        for (int i = 0; i < 2; i++) begin
            m_data[i] = 0;
            m_vld[i]  = 0;
            m_cnt[i]  = 0;
        end
    endfunction

    function automatic bit model_ready(bit r, bit s, bit p0, bit p1);
        int lane;
        lane = s ? 0 : m_next;
        return !r && !(lane == 0 ? p0 : p1);
    endfunction

    function automatic void model_step(bit r, bit v, int d, bit s, bit p0, bit p1);
        int lane;
        bit rdy;
        if (r) begin
            model_reset();
            return;
        end
        lane = s ? 0 : m_next;
        rdy  = model_ready(r, s, p0, p1);
        m_vld[0] = 0;
        m_vld[1] = 0;
        if (v && rdy) begin
            m_data[lane] = d;
            m_vld[lane]  = 1;
            m_cnt[lane]  = (m_cnt[lane] + 1) % 256;
            m_next       = 1 - lane;
        end else begin
            if (s) m_next = 0;
            if (v && m_running) m_err = 1;
        end
        m_running = 1;
    endfunction

    task automatic cyc(input bit r, input bit v, input int d, input bit s,
                       input bit p0, input bit p1, input bit full_chk = 1);
        reset = r; valid_in = v; data_in = 8'(d); sync_in = s; pause_0 = p0; pause_1 = p1;
        #1;
        chk("ready_in", 32'(ready_in), 32'(model_ready(r, s, p0, p1)));
        @(posedge clk_2f);
        model_step(r, v, d, s, p0, p1);
        #1;
        if (full_chk) begin
            chk("valid_out_0", 32'(valid_out_0), 32'(m_vld[0]));
            chk("valid_out_1", 32'(valid_out_1), 32'(m_vld[1]));
            chk("data_out_0",  32'(data_out_0),  32'(m_data[0]));
            chk("data_out_1",  32'(data_out_1),  32'(m_data[1]));
            chk("selector",    32'(selector),    32'(m_next));
            chk("words_0",     32'(words_0),     32'(m_cnt[0]));
            chk("words_1",     32'(words_1),     32'(m_cnt[1]));
            chk("err_ovf",     32'(err_ovf),     32'(m_err));
        end
    endtask

    initial begin
        model_reset();
        reset = 1; valid_in = 0; data_in = 0; sync_in = 0; pause_0 = 0; pause_1 = 0;
        #2;

        // Reset with traffic present: everything stays zero, ready low.
        cyc(1, 1, 8'hAA, 0, 0, 0);
        cyc(1, 1, 8'hAA, 0, 0, 0);
        chk("rst_words_0", 32'(words_0), 32'd0);
        chk("rst_err", 32'(err_ovf), 32'd0);

        // Plain alternation.
        cyc(0, 1, 8'h01, 0, 0, 0);
        chk("alt_lane0_first", 32'(data_out_0), 32'h01);
        cyc(0, 1, 8'h02, 0, 0, 0);
        chk("alt_lane1_second", 32'(data_out_1), 32'h02);
        cyc(0, 1, 8'h03, 0, 0, 0);
        cyc(0, 1, 8'h04, 0, 0, 0);
        chk("alt_words_1", 32'(words_1), 32'd2);
        chk("alt_selector", 32'(selector), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);

        // Pause on target lane with valid held: drop and sticky error.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 8'h10, 0, 0, 0);
        cyc(0, 1, 8'h11, 0, 0, 1);
        chk("ovf_err_set", 32'(err_ovf), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("ovf_sticky", 32'(err_ovf), 32'd1);

        // Same with valid gated: word waits for pause to fall, no error.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 8'h10, 0, 0, 0);
        cyc(0, 0, 8'h11, 0, 0, 1);
        cyc(0, 1, 8'h11, 0, 1, 0);
        chk("gated_lane1", 32'(data_out_1), 32'h11);
        chk("gated_no_err", 32'(err_ovf), 32'd0);

        // Sync realigns the second word onto lane 0.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 8'h20, 0, 0, 0);
        cyc(0, 1, 8'h21, 1, 0, 0);
        chk("sync_lane0", 32'(data_out_0), 32'h21);
        chk("sync_w0", 32'(words_0), 32'd2);
        chk("sync_w1", 32'(words_1), 32'd0);

        // Sync + pause_0 + valid: drop, error, pointer to lane 0.
        cyc(0, 1, 8'h22, 1, 1, 0);
        chk("sync_pause_err", 32'(err_ovf), 32'd1);

        // Counter wrap.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 510; i++) cyc(0, 1, i % 256, 0, 0, 0, 0);
        cyc(0, 1, 8'h5A, 0, 0, 0);
        chk("wrap_w0", 32'(words_0), 32'd0);
        chk("wrap_w1", 32'(words_1), 32'd255);

        // Reset mid-stream while lane 1 is presenting a word.
        cyc(0, 1, 8'h66, 0, 1, 0);
        chk("mid_v1", 32'(valid_out_1), 32'd1);
        cyc(1, 1, 8'h77, 0, 0, 0);
        chk("mid_rst_d1", 32'(data_out_1), 32'd0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(99) < 2), ($urandom_range(99) < 70), $urandom_range(255),
                ($urandom_range(99) < 10), ($urandom_range(99) < 25), ($urandom_range(99) < 25));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
